// File: rtl/idx2cloud_stream.sv
// Pinhole back-projection of (x, y, depth) pixels into camera-frame points, with
// valid/ready backpressure, a pipelined fractional divider, a depth-range mask and point counter.
module idx2cloud_stream #(
  parameter int unsigned H_SIZE_BW  = 10,
  parameter int unsigned V_SIZE_BW  = 10,
  parameter int unsigned DEPTH_BW   = 16,
  parameter int unsigned FRAC_BW    = 8,
  parameter int unsigned F_BW       = 24,
  parameter int unsigned DIV_STAGES = 5,
  parameter int unsigned CLOUD_BW   = 42,
  parameter int unsigned CNT_BW     = 20
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_sof,
  input  logic [H_SIZE_BW-1:0]         i_idx_x,
  input  logic [V_SIZE_BW-1:0]         i_idx_y,
  input  logic [DEPTH_BW-1:0]          i_depth,
  input  logic [F_BW-1:0]              r_fx,
  input  logic [F_BW-1:0]              r_fy,
  input  logic [H_SIZE_BW+FRAC_BW-1:0] r_cx,
  input  logic [V_SIZE_BW+FRAC_BW-1:0] r_cy,
  input  logic [DEPTH_BW-1:0]          r_depth_min,
  input  logic [DEPTH_BW-1:0]          r_depth_max,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_sof,
  output logic                         o_mask,
  output logic [CLOUD_BW-1:0]          o_cloud_x,
  output logic [CLOUD_BW-1:0]          o_cloud_y,
  output logic [CLOUD_BW-1:0]          o_cloud_z,
  output logic [CNT_BW-1:0]            o_point_cnt
);

  localparam int unsigned HV_BW   = (H_SIZE_BW > V_SIZE_BW) ? H_SIZE_BW : V_SIZE_BW;
  localparam int unsigned DX_BW   = H_SIZE_BW + FRAC_BW + 1;
  localparam int unsigned DY_BW   = V_SIZE_BW + FRAC_BW + 1;
  localparam int unsigned DXM_BW  = DX_BW - 1;
  localparam int unsigned DYM_BW  = DY_BW - 1;
  localparam int unsigned NUM_BW  = HV_BW + 2 * FRAC_BW + DEPTH_BW;
  localparam int unsigned STEP_N  = (NUM_BW + DIV_STAGES - 1) / DIV_STAGES;
  localparam int unsigned LAST    = DIV_STAGES - 1;

  logic adv;
  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;

  // Stage 1: offsets from the principal point, mask, and register snapshot
  logic [DX_BW-1:0] dx_d;
  logic [DY_BW-1:0] dy_d;
  logic             mask_d;

  assign dx_d   = {1'b0, i_idx_x, {FRAC_BW{1'b0}}} - {1'b0, r_cx};
  assign dy_d   = {1'b0, i_idx_y, {FRAC_BW{1'b0}}} - {1'b0, r_cy};
  assign mask_d = (i_depth >= r_depth_min) && (i_depth <= r_depth_max) &&
                  (r_fx != '0) && (r_fy != '0);

  logic                s1_valid_q, s1_sof_q, s1_mask_q;
  logic [DX_BW-1:0]    s1_dx_q;
  logic [DY_BW-1:0]    s1_dy_q;
  logic [DEPTH_BW-1:0] s1_depth_q;
  logic [F_BW-1:0]     s1_fx_q, s1_fy_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_mask_q  <= 1'b0;
      s1_dx_q    <= '0;
      s1_dy_q    <= '0;
      s1_depth_q <= '0;
      s1_fx_q    <= '0;
      s1_fy_q    <= '0;
    end else if (adv) begin
      s1_valid_q <= i_valid;
      s1_sof_q   <= i_sof;
      s1_mask_q  <= mask_d;
      s1_dx_q    <= dx_d;
      s1_dy_q    <= dy_d;
      s1_depth_q <= i_depth;
      s1_fx_q    <= r_fx;
      s1_fy_q    <= r_fy;
    end
  end

  // Stage 2: sign/magnitude split so the divider works on unsigned values
  logic [DXM_BW-1:0] mag_dx;
  logic [DYM_BW-1:0] mag_dy;
  logic [NUM_BW-1:0] num_x0, num_y0;

  assign mag_dx = s1_dx_q[DX_BW-1] ? DXM_BW'(-s1_dx_q) : s1_dx_q[DXM_BW-1:0];
  assign mag_dy = s1_dy_q[DY_BW-1] ? DYM_BW'(-s1_dy_q) : s1_dy_q[DYM_BW-1:0];
  assign num_x0 = (NUM_BW'(mag_dx) * NUM_BW'(s1_depth_q)) << FRAC_BW;
  assign num_y0 = (NUM_BW'(mag_dy) * NUM_BW'(s1_depth_q)) << FRAC_BW;

  // Restoring division, STEP_N quotient bits per stage; num shifts out dividend, shifts in quotient
  function automatic logic [F_BW+NUM_BW-1:0] div_steps(input logic [F_BW+NUM_BW-1:0] st,
                                                      input logic [F_BW-1:0] d,
                                                      input int unsigned first);
    logic [F_BW-1:0]   rem;
    logic [NUM_BW-1:0] num;
    logic [F_BW:0]     tmp;
    {rem, num} = st;
    for (int unsigned k = 0; k < STEP_N; k++) begin
      if (first + k < NUM_BW) begin
        tmp = {rem, num[NUM_BW-1]};
        num = num << 1;
        if (tmp >= {1'b0, d}) begin
          tmp    = tmp - {1'b0, d};
          num[0] = 1'b1;
        end
        rem = tmp[F_BW-1:0];
      end
    end
    return {rem, num};
  endfunction

  logic [DIV_STAGES-1:0] dv_valid_q, dv_sof_q, dv_mask_q, dv_neg_x_q, dv_neg_y_q;
  logic [NUM_BW-1:0]     dv_num_x_q  [DIV_STAGES];
  logic [NUM_BW-1:0]     dv_num_y_q  [DIV_STAGES];
  logic [F_BW-1:0]       dv_rem_x_q  [DIV_STAGES];
  logic [F_BW-1:0]       dv_rem_y_q  [DIV_STAGES];
  logic [F_BW-1:0]       dv_fx_q     [DIV_STAGES];
  logic [F_BW-1:0]       dv_fy_q     [DIV_STAGES];
  logic [DEPTH_BW-1:0]   dv_depth_q  [DIV_STAGES];
  logic [NUM_BW-1:0]     num_x_nxt   [DIV_STAGES];
  logic [NUM_BW-1:0]     num_y_nxt   [DIV_STAGES];
  logic [F_BW-1:0]       rem_x_nxt   [DIV_STAGES];
  logic [F_BW-1:0]       rem_y_nxt   [DIV_STAGES];

  for (genvar s = 0; s < DIV_STAGES; s++) begin : g_div
    localparam int unsigned First = s * STEP_N;
    assign {rem_x_nxt[s], num_x_nxt[s]} = div_steps({dv_rem_x_q[s], dv_num_x_q[s]},
                                                    dv_fx_q[s], First);
    assign {rem_y_nxt[s], num_y_nxt[s]} = div_steps({dv_rem_y_q[s], dv_num_y_q[s]},
                                                    dv_fy_q[s], First);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dv_valid_q <= '0;
      dv_sof_q   <= '0;
      dv_mask_q  <= '0;
      dv_neg_x_q <= '0;
      dv_neg_y_q <= '0;
      for (int unsigned s = 0; s < DIV_STAGES; s++) begin
        dv_num_x_q[s] <= '0;
        dv_num_y_q[s] <= '0;
        dv_rem_x_q[s] <= '0;
        dv_rem_y_q[s] <= '0;
        dv_fx_q[s]    <= '0;
        dv_fy_q[s]    <= '0;
        dv_depth_q[s] <= '0;
      end
    end else if (adv) begin
      dv_valid_q[0] <= s1_valid_q;
      dv_sof_q[0]   <= s1_sof_q;
      dv_mask_q[0]  <= s1_mask_q;
      dv_neg_x_q[0] <= s1_dx_q[DX_BW-1];
      dv_neg_y_q[0] <= s1_dy_q[DY_BW-1];
      dv_num_x_q[0] <= num_x0;
      dv_num_y_q[0] <= num_y0;
      dv_rem_x_q[0] <= '0;
      dv_rem_y_q[0] <= '0;
      dv_fx_q[0]    <= s1_fx_q;
      dv_fy_q[0]    <= s1_fy_q;
      dv_depth_q[0] <= s1_depth_q;
      for (int unsigned s = 1; s < DIV_STAGES; s++) begin
        dv_valid_q[s] <= dv_valid_q[s-1];
        dv_sof_q[s]   <= dv_sof_q[s-1];
        dv_mask_q[s]  <= dv_mask_q[s-1];
        dv_neg_x_q[s] <= dv_neg_x_q[s-1];
        dv_neg_y_q[s] <= dv_neg_y_q[s-1];
        dv_num_x_q[s] <= num_x_nxt[s-1];
        dv_num_y_q[s] <= num_y_nxt[s-1];
        dv_rem_x_q[s] <= rem_x_nxt[s-1];
        dv_rem_y_q[s] <= rem_y_nxt[s-1];
        dv_fx_q[s]    <= dv_fx_q[s-1];
        dv_fy_q[s]    <= dv_fy_q[s-1];
        dv_depth_q[s] <= dv_depth_q[s-1];
      end
    end
  end

  // Final divider stage feeds the output register directly: re-apply sign, resize, mask
  logic [NUM_BW:0]               qx_s, qy_s;
  logic [NUM_BW+CLOUD_BW:0]      qx_w, qy_w;
  logic [CLOUD_BW+DEPTH_BW+FRAC_BW-1:0] z_w;
  logic [CLOUD_BW-1:0]           cloud_x_d, cloud_y_d, cloud_z_d;
  logic                          unused_rem;

  assign unused_rem = ^{rem_x_nxt[LAST], rem_y_nxt[LAST]};

  always_comb begin
    qx_s = dv_neg_x_q[LAST] ? -{1'b0, num_x_nxt[LAST]} : {1'b0, num_x_nxt[LAST]};
    qy_s = dv_neg_y_q[LAST] ? -{1'b0, num_y_nxt[LAST]} : {1'b0, num_y_nxt[LAST]};
    qx_w = {{CLOUD_BW{qx_s[NUM_BW]}}, qx_s};
    qy_w = {{CLOUD_BW{qy_s[NUM_BW]}}, qy_s};
    z_w  = {{CLOUD_BW{1'b0}}, dv_depth_q[LAST], {FRAC_BW{1'b0}}};
    cloud_x_d = '0;
    cloud_y_d = '0;
    cloud_z_d = '0;
    if (dv_mask_q[LAST]) begin
      cloud_x_d = qx_w[CLOUD_BW-1:0];
      cloud_y_d = qy_w[CLOUD_BW-1:0];
      cloud_z_d = z_w[CLOUD_BW-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_sof     <= 1'b0;
      o_mask    <= 1'b0;
      o_cloud_x <= '0;
      o_cloud_y <= '0;
      o_cloud_z <= '0;
    end else if (adv) begin
      o_valid   <= dv_valid_q[LAST];
      o_sof     <= dv_valid_q[LAST] & dv_sof_q[LAST];
      o_mask    <= dv_valid_q[LAST] & dv_mask_q[LAST];
      o_cloud_x <= cloud_x_d;
      o_cloud_y <= cloud_y_d;
      o_cloud_z <= cloud_z_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_point_cnt <= '0;
    end else if (o_valid && i_ready) begin
      if (o_sof) begin
        o_point_cnt <= CNT_BW'(o_mask);
      end else if (!(&o_point_cnt)) begin
        o_point_cnt <= o_point_cnt + CNT_BW'(o_mask);
      end
    end
  end

endmodule

// File: tb/tb_idx2cloud_stream.sv
// Bench for idx2cloud_stream: directed and random pixels checked against an arithmetic model
// of pinhole back-projection, masking, latency, backpressure and frame point counting.
module tb_idx2cloud_stream;

  localparam int unsigned LAT     = 7;
  localparam int          CNT_MAX = (1 << 20) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, o_ready, i_sof, i_ready;
  logic [9:0]  i_idx_x, i_idx_y;
  logic [15:0] i_depth, r_depth_min, r_depth_max;
  logic [23:0] r_fx, r_fy;
  logic [17:0] r_cx, r_cy;
  logic        o_valid, o_sof, o_mask;
  logic [41:0] o_cloud_x, o_cloud_y, o_cloud_z;
  logic [19:0] o_point_cnt;

  always #5 clk = ~clk;

  idx2cloud_stream dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_sof       (i_sof),
    .i_idx_x     (i_idx_x),
    .i_idx_y     (i_idx_y),
    .i_depth     (i_depth),
    .r_fx        (r_fx),
    .r_fy        (r_fy),
    .r_cx        (r_cx),
    .r_cy        (r_cy),
    .r_depth_min (r_depth_min),
    .r_depth_max (r_depth_max),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_sof       (o_sof),
    .o_mask      (o_mask),
    .o_cloud_x   (o_cloud_x),
    .o_cloud_y   (o_cloud_y),
    .o_cloud_z   (o_cloud_z),
    .o_point_cnt (o_point_cnt)
  );

  typedef struct {
    int x, y, d;
    bit sof;
    int cx, cy, fx, fy, dmin, dmax;
  } pix_t;

  typedef struct {
    logic [41:0] cx, cy, cz;
    bit          mask, sof;
    int          stamp;
  } exp_t;

  pix_t pend[$];
  exp_t expq[$];
  int n_checks = 0, n_fail = 0;
  int adv_cnt = 0, model_cnt = 0, n_hs = 0;
  int cur_cx, cur_cy, cur_fx, cur_fy, cur_dmin, cur_dmax;
  bit rand_ready = 1'b0, rand_valid = 1'b0;
  logic [41:0] last_x, last_y, last_z, k;
  logic        last_mask;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input pix_t p, input int stamp);
    exp_t   e;
    longint qx, qy, qz;
    e.mask  = (p.d >= p.dmin) && (p.d <= p.dmax) && (p.fx != 0) && (p.fy != 0);
    e.sof   = p.sof;
    e.stamp = stamp;
    qx = 0;
    qy = 0;
    qz = 0;
    if (e.mask) begin
      qx = ((longint'(p.x) * 256 - p.cx) * p.d * 256) / p.fx;
      qy = ((longint'(p.y) * 256 - p.cy) * p.d * 256) / p.fy;
      qz = longint'(p.d) * 256;
    end
    e.cx = qx[41:0];
    e.cy = qy[41:0];
    e.cz = qz[41:0];
    return e;
  endfunction

  task automatic push(input int x, input int y, input int d, input bit sof);
    pix_t p;
    p.x = x; p.y = y; p.d = d; p.sof = sof;
    p.cx = cur_cx; p.cy = cur_cy; p.fx = cur_fx; p.fy = cur_fy;
    p.dmin = cur_dmin; p.dmax = cur_dmax;
    pend.push_back(p);
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic step();
    bit   exp_valid, adv;
    exp_t e;
    pix_t p;
    if (pend.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
      p = pend[0];
      i_valid = 1'b1;
      i_sof = p.sof;
      i_idx_x = p.x[9:0];
      i_idx_y = p.y[9:0];
      i_depth = p.d[15:0];
      r_cx = p.cx[17:0];
      r_cy = p.cy[17:0];
      r_fx = p.fx[23:0];
      r_fy = p.fy[23:0];
      r_depth_min = p.dmin[15:0];
      r_depth_max = p.dmax[15:0];
    end else begin
      i_valid = 1'b0;
      i_sof = 1'b0;
    end
    i_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    @(negedge clk);
    exp_valid = (expq.size() > 0) && (expq[0].stamp + LAT == adv_cnt);
    adv = !(exp_valid && !i_ready);
    check("o_valid", o_valid, exp_valid);
    check("o_ready", o_ready, adv);
    check("o_point_cnt", o_point_cnt, model_cnt);
    if (exp_valid) begin
      e = expq[0];
      check("o_cloud_x", o_cloud_x, e.cx);
      check("o_cloud_y", o_cloud_y, e.cy);
      check("o_cloud_z", o_cloud_z, e.cz);
      check("o_mask", o_mask, e.mask);
      check("o_sof", o_sof, e.sof);
      if (i_ready) begin
        void'(expq.pop_front());
        n_hs++;
        last_x = o_cloud_x;
        last_y = o_cloud_y;
        last_z = o_cloud_z;
        last_mask = o_mask;
        if (e.sof) model_cnt = int'(e.mask);
        else if (model_cnt < CNT_MAX) model_cnt = model_cnt + int'(e.mask);
      end
    end
    if (i_valid && adv) expq.push_back(model(pend.pop_front(), adv_cnt));
    if (adv) adv_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((pend.size() > 0 || expq.size() > 0) && n < 400) begin
      step();
      n++;
    end
    check("drain_timeout", pend.size() + expq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    int hs0;
    rst_n = 1'b0;
    i_valid = 1'b0; i_sof = 1'b0; i_ready = 1'b1;
    i_idx_x = '0; i_idx_y = '0; i_depth = '0;
    r_fx = '0; r_fy = '0; r_cx = '0; r_cy = '0; r_depth_min = '0; r_depth_max = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_sof", o_sof, 0);
    check("rst_o_mask", o_mask, 0);
    check("rst_cloud_x", o_cloud_x, 0);
    check("rst_cloud_z", o_cloud_z, 0);
    check("rst_cnt", o_point_cnt, 0);
    check("rst_o_ready", o_ready, 1);
    rst_n = 1'b1;

    cur_cx = 20480; cur_cy = 20480; cur_fx = 128000; cur_fy = 128000;
    cur_dmin = 0; cur_dmax = 65535;
    push(100, 100, 1000, 1'b1);
    drain();
    check("exact_x", last_x, 42'd10240);
    check("exact_y", last_y, 42'd10240);
    check("exact_z", last_z, 42'd256000);
    check("exact_mask", last_mask, 1);

    push(0, 100, 1000, 1'b0);
    drain();
    k = -42'sd40960;
    check("neg_x", last_x, k);
    push(100, 100, 3, 1'b0);
    drain();
    check("frac_x", last_x, 42'd30);
    push(60, 100, 3, 1'b0);
    drain();
    k = -42'sd30;
    check("trunc_x", last_x, k);

    cur_dmin = 100; cur_dmax = 4000;
    push(100, 100, 0, 1'b0);
    drain();
    check("d0_mask", last_mask, 0);
    check("d0_x", last_x, 0);
    check("d0_z", last_z, 0);
    push(100, 100, 4000, 1'b0);
    drain();
    check("dmax_mask", last_mask, 1);
    push(100, 100, 4001, 1'b0);
    drain();
    check("dover_mask", last_mask, 0);
    cur_fy = 0;
    push(300, 700, 1000, 1'b0);
    drain();
    check("fy0_mask", last_mask, 0);
    check("fy0_x", last_x, 0);
    check("fy0_y", last_y, 0);
    cur_fy = 128000;

    // Random stream under random backpressure, registers changing per pixel
    rand_ready = 1'b1;
    rand_valid = 1'b1;
    hs0 = n_hs;
    for (int i = 0; i < 20; i++) begin
      cur_cx = $urandom_range(0, 262143);
      cur_cy = $urandom_range(0, 262143);
      cur_fx = $urandom_range(1, 1 << 20);
      cur_fy = $urandom_range(1, 1 << 20);
      push($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 5000), 1'b0);
    end
    drain();
    check("stream_count", n_hs - hs0, 20);

    cur_cx = 20480; cur_cy = 20480; cur_fx = 128000; cur_fy = 128000;
    for (int i = 0; i < 10; i++) begin
      push(i * 37, i * 11, (i % 3 == 2) ? 50 : 200 + i * 100, i == 0);
    end
    drain();
    check("frame_a_cnt", o_point_cnt, 7);
    push(5, 5, 500, 1'b1);
    drain();
    check("frame_b_cnt", o_point_cnt, 1);

    // Reset with four points in flight
    rand_ready = 1'b0;
    rand_valid = 1'b0;
    for (int i = 0; i < 4; i++) push(100 + i, 50, 1000, 1'b0);
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_sof", o_sof, 0);
    check("mid_rst_mask", o_mask, 0);
    check("mid_rst_x", o_cloud_x, 0);
    check("mid_rst_y", o_cloud_y, 0);
    check("mid_rst_z", o_cloud_z, 0);
    check("mid_rst_cnt", o_point_cnt, 0);
    pend.delete();
    expq.delete();
    model_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) step();
    push(100, 100, 1000, 1'b0);
    drain();
    check("post_rst_x", last_x, 42'd10240);
    check("post_rst_cnt", o_point_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/idx2cloud_stream.md
Name: idx2cloud_stream

Overview:
- Back-projects a pixel (x, y, depth) into a camera-frame 3D point using pinhole intrinsics:
  - X = (x - cx) * d / fx
  - Y = (y - cy) * d / fy
  - Z = d
- Parametrised, stallable successor of the fixed 6-cycle back-projector, sitting between the depth-frame reader and the cloud/warp stages of the RGBD VO pipeline.
- New behaviour:
  - valid/ready backpressure with full-pipeline stall.
  - Fractional-precision division.
  - Depth-range validity mask.
  - SOF propagation.
  - Per-frame valid-point counter.

Parameters:
- H_SIZE_BW, 10, column index width
- V_SIZE_BW, 10, row index width
- DEPTH_BW, 16, raw depth width (unsigned)
- FRAC_BW, 8, fraction bits of cx/cy/fx/fy and of cloud outputs
- F_BW, 24, fx/fy width (unsigned, FRAC_BW fraction bits)
- DIV_STAGES, 5, divider pipeline stages; total latency LAT = DIV_STAGES + 2
- CLOUD_BW, 42, output coordinate width (signed two's complement, FRAC_BW fraction bits)
- CNT_BW, 20, point counter width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_valid  in  1  input pixel valid
- o_ready  out  1  input accepted when i_valid && o_ready
- i_sof  in  1  first pixel of frame
- i_idx_x  in  H_SIZE_BW  column
- i_idx_y  in  V_SIZE_BW  row
- i_depth  in  DEPTH_BW  raw depth
- r_fx, r_fy  in  F_BW  focal lengths
- r_cx  in  H_SIZE_BW+FRAC_BW  principal point x
- r_cy  in  V_SIZE_BW+FRAC_BW  principal point y
- r_depth_min, r_depth_max  in  DEPTH_BW  valid depth range, inclusive
- o_valid  out  1  output point valid
- i_ready  in  1  downstream ready
- o_sof  out  1  SOF travelling with point
- o_mask  out  1  1 = geometrically valid point
- o_cloud_x, o_cloud_y, o_cloud_z  out  CLOUD_BW  point coordinates
- o_point_cnt  out  CNT_BW  masked-valid points in current frame

Behaviour:
- One clock (i_clk); asynchronous active-low reset (i_rst_n).
- Reset: all pipeline valids, o_valid, o_sof, o_mask, o_cloud_*, o_point_cnt = 0; o_ready = 1 from the first cycle after reset.
- Reset mid-operation discards all in-flight points and clears the counter.
- Stall rule:
  - adv = !o_valid || i_ready, and o_ready = adv (combinational).
  - When adv = 0, every stage, including the divider, holds its contents.
  - Bubbles are not collapsed; throughput is 1 point/cycle with i_ready held high.
- Latency: exactly LAT advancing cycles from acceptance to o_valid (default 7). o_valid, o_cloud_* and o_sof stay stable while o_valid && !i_ready.
- Register sampling: r_* are sampled at acceptance and carried with the pixel. A register change affects only later-accepted pixels.
- Arithmetic, with cx, cy, fx, fy all in FRAC_BW fixed point:
  - Stage 1: dx = (i_idx_x << FRAC_BW) - r_cx, signed, H_SIZE_BW+FRAC_BW+1 bits; dy likewise.
  - Stage 2: px = dx * depth, signed full width.
  - Divider stages: qx = (px << FRAC_BW) / fx, signed, truncating toward zero. The result carries FRAC_BW fraction bits; qy likewise with fy.
  - o_cloud_x = qx sign-extended or truncated to CLOUD_BW; o_cloud_y likewise from qy.
  - o_cloud_z = depth << FRAC_BW, zero-extended.
- Mask:
  - o_mask = (r_depth_min <= depth <= r_depth_max) && fx != 0 && fy != 0.
  - When o_mask = 0, o_cloud_x/y/z are forced to 0. A divide-by-zero result never reaches the outputs.
- Counter:
  - Updates only on an output handshake (o_valid && i_ready).
  - If o_sof = 1: o_point_cnt <= o_mask.
  - Else: o_point_cnt <= o_point_cnt + o_mask, saturating at all-ones.

Test Plan:
- Exact positive point, FRAC_BW=8, r_cx=20480 (80.0), r_fx=128000 (500.0), x=100, depth=1000 -> o_cloud_x=10240 (40.0), o_cloud_z=256000, o_mask=1, o_valid exactly 7 cycles after acceptance.
- Negative and fractional point, same registers:
  - x=0, depth=1000 -> o_cloud_x=-40960.
  - x=100, depth=3 -> o_cloud_x=30.
  - x=60 (dx=-20.0), depth=3 -> o_cloud_x=-30 (truncation toward zero).
- Mask, with r_depth_min=100, r_depth_max=4000:
  - depth=0 -> o_mask=0, cloud all 0.
  - depth=4000 -> o_mask=1.
  - depth=4001 -> o_mask=0.
  - r_fy=0 -> o_mask=0 with no X/Y garbage.
- Backpressure:
  - Stream of 20 points with i_ready toggling randomly -> output order, values and count all preserved, with no duplicates.
  - o_valid/data stable while i_ready=0.
  - o_ready low exactly when o_valid && !i_ready.
- Counter: frame A of 10 points (3 masked invalid), then frame B with SOF -> o_point_cnt=7 at end of A; resets to 1 on B's first valid point.
- Reset asserted with 4 points in flight -> all outputs 0 immediately, no stale point emerges after release, o_point_cnt=0.
